// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer engine: FSM state
// encoding and the width helpers used for the dot product and requantisation.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MAC,
        S_STORE,
        S_DONE
    } fc_state_t;

    // Product of a zero-extended unsigned lane and a signed weight.
    function automatic int fc_prod_w(input int dw);
        return 2 * dw + 1;
    endfunction

    // Sum of in_num products without overflow.
    function automatic int fc_sum_w(input int in_num, input int dw);
        return fc_prod_w(dw) + $clog2(in_num);
    endfunction

    // Accumulator holding the dot product plus the pre-shifted bias.
    function automatic int fc_acc_w(input int in_num, input int dw, input int shift);
        int s;
        int b;
        s = fc_sum_w(in_num, dw);
        b = dw + shift;
        return ((s > b) ? s : b) + 1;
    endfunction

    // Index width for a neuron counter / argmax output.
    function automatic int fc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_dot_tree.sv
// Combinational dot product: unsigned activations times signed weights,
// summed at full precision. The parent registers the result.
module fc_dot_tree import fc_pkg::*; #(
    parameter int IN_NUM = 16,
    parameter int DW     = 8
) (
    input  logic [IN_NUM*DW-1:0]                      i_act,
    input  logic [IN_NUM*DW-1:0]                      i_wt,
    output logic signed [fc_sum_w(IN_NUM, DW)-1:0]    o_sum
);

    localparam int PW = fc_prod_w(DW);
    localparam int SW = fc_sum_w(IN_NUM, DW);

    logic signed [PW-1:0] w_prod [IN_NUM];
    logic signed [SW-1:0] w_sum;

    // Per-lane products, activation treated as unsigned
    always_comb begin
        for (int unsigned i = 0; i < IN_NUM; i++) begin
            w_prod[i] = PW'($signed({1'b0, i_act[i*DW +: DW]})) * PW'($signed(i_wt[i*DW +: DW]));
        end
    end

    // Reduction of all products with sign extension to the sum width
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < IN_NUM; i++) begin
            w_sum = w_sum + SW'(w_prod[i]);
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: one neuron per FETCH/MAC/STORE triple,
// requantised by an arithmetic right shift with saturation.
// Optional feature macro: FC_ARGMAX_EN (running argmax on max_idx).
module fc_layer_engine import fc_pkg::*; #(
    parameter int IN_NUM      = 16,
    parameter int OUT_NUM     = 10,
    parameter int DW          = 8,
    parameter int AW          = 9,
    parameter int WEIGHT_BASE = 443,
    parameter int SHIFT       = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_NUM*DW-1:0]             in_data,
    output logic [AW-1:0]                    weight_addr,
    input  logic [(IN_NUM+1)*DW-1:0]         weight_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_NUM*DW-1:0]            out_data,
    output logic [fc_idx_w(OUT_NUM)-1:0]     max_idx
);

    localparam int SW   = fc_sum_w(IN_NUM, DW);
    localparam int ACCW = fc_acc_w(IN_NUM, DW, SHIFT);
    localparam int KW   = fc_idx_w(OUT_NUM);

    localparam logic [KW-1:0]          K_LAST  = KW'(OUT_NUM - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (DW - 1)));

    fc_state_t                r_state;
    logic [KW-1:0]            r_k;
    logic [IN_NUM*DW-1:0]     r_act;
    logic signed [ACCW-1:0]   r_acc;
    logic [OUT_NUM*DW-1:0]    r_out;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic signed [SW-1:0]     w_sum;
    logic signed [ACCW-1:0]   w_bias_sh;
    logic signed [ACCW-1:0]   w_acc_next;
    logic signed [ACCW-1:0]   w_shr;
    logic signed [DW-1:0]     w_sat;

    fc_dot_tree #(
        .IN_NUM (IN_NUM),
        .DW     (DW)
    ) u_dot (
        .i_act  (r_act),
        .i_wt   (weight_data[IN_NUM*DW-1:0]),
        .o_sum  (w_sum)
    );

    assign w_bias_sh  = ACCW'($signed(weight_data[IN_NUM*DW +: DW])) <<< SHIFT;
    assign w_acc_next = ACCW'(w_sum) + w_bias_sh;
    assign w_shr      = r_acc >>> SHIFT;

    // Clamp the requantised accumulator into the signed DW range
    always_comb begin
        if (w_shr > SAT_MAX) begin
            w_sat = SAT_MAX[DW-1:0];
        end else if (w_shr < SAT_MIN) begin
            w_sat = SAT_MIN[DW-1:0];
        end else begin
            w_sat = w_shr[DW-1:0];
        end
    end

    // Control FSM with registered handshake outputs and result storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_act       <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_act      <= in_data;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc   <= w_acc_next;
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    r_out[r_k*DW +: DW] <= w_sat;
                    if (r_k == K_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FC_ARGMAX_EN
    logic signed [DW-1:0] r_max_val;
    logic [KW-1:0]        r_max_idx;

    // Running maximum; strict compare keeps the lowest index on ties
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (r_state == S_STORE) begin
            if (r_k == '0 || w_sat > r_max_val) begin
                r_max_val <= w_sat;
                r_max_idx <= r_k;
            end
        end
    end

    assign max_idx = r_max_idx;
`else
    assign max_idx = '0;
`endif

    assign weight_addr = AW'(WEIGHT_BASE) + AW'(r_k);
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: default instance plus a small
// parameter-swept instance whose ROM window wraps around address 0.
module tb_fc_layer_engine;

    localparam int IN  = 16;
    localparam int ON  = 10;
    localparam int DW  = 8;
    localparam int IN2 = 4;
    localparam int ON2 = 3;

`ifdef FC_ARGMAX_EN
    localparam bit ARGMAX = 1'b1;
`else
    localparam bit ARGMAX = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   in_valid, in_ready, out_valid, out_ready;
    logic [IN*DW-1:0]       in_data;
    logic [8:0]             weight_addr;
    logic [(IN+1)*DW-1:0]   weight_data;
    logic [ON*DW-1:0]       out_data;
    logic [3:0]             max_idx;
    logic [(IN+1)*DW-1:0]   rom [512];

    logic                   in_valid2, in_ready2, out_valid2, out_ready2;
    logic [IN2*DW-1:0]      in_data2;
    logic [8:0]             weight_addr2;
    logic [(IN2+1)*DW-1:0]  weight_data2;
    logic [ON2*DW-1:0]      out_data2;
    logic [1:0]             max_idx2;
    logic [(IN2+1)*DW-1:0]  rom2 [512];

    int checks = 0;
    int errors = 0;

    fc_layer_engine dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .max_idx     (max_idx)
    );

    fc_layer_engine #(
        .IN_NUM      (IN2),
        .OUT_NUM     (ON2),
        .DW          (DW),
        .AW          (9),
        .WEIGHT_BASE (510),
        .SHIFT       (7)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_data     (in_data2),
        .weight_addr (weight_addr2),
        .weight_data (weight_data2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_data    (out_data2),
        .max_idx     (max_idx2)
    );

    // Synchronous weight ROMs: data one cycle after address
    always @(posedge clk) begin
        weight_data  <= rom[weight_addr];
        weight_data2 <= rom2[weight_addr2];
    end

    function automatic logic [ON*DW-1:0] pack(input int e[ON]);
        logic [ON*DW-1:0] r;
        for (int k = 0; k < ON; k++) r[k*DW +: DW] = 8'(e[k]);
        return r;
    endfunction

    task automatic load_neuron(input int k, input logic [7:0] w, input logic [7:0] b);
        rom[443 + k] = {b, {IN{w}}};
    endtask

    task automatic start_vec(input logic [IN*DW-1:0] d);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_ready got %b want 1", in_ready);
        end
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the handshake edge (cyc=1) until out_valid is seen
    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (cyc == pulse_at) begin
                in_valid = 1'b1;
                in_data  = '0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (max_idx !== 4'd0) begin errors++; $display("FAIL reset_max_idx got %0d want 0", max_idx); end
        checks++; if (weight_addr !== 9'd443) begin errors++; $display("FAIL reset_addr got %0d want 443", weight_addr); end
        checks++; if (weight_addr2 !== 9'd510) begin errors++; $display("FAIL reset_addr2 got %0d want 510", weight_addr2); end
    endtask

    task automatic test_mixed();
        int cyc;
        int e[ON];
        logic [3:0] ei;
        for (int k = 0; k < ON; k++) load_neuron(k, 8'(k), 8'hFD);
        e = '{-3, -3, -2, -2, -1, -1, 0, 0, 1, 1};
        ei = ARGMAX ? 4'd8 : 4'd0;
        start_vec({IN{8'd4}});
        wait_done(5, cyc);
        checks++; if (cyc !== 31) begin errors++; $display("FAIL mixed_latency got %0d want 31", cyc); end
        checks++; if (out_data !== pack(e)) begin errors++; $display("FAIL mixed_data got %h want %h", out_data, pack(e)); end
        checks++; if (max_idx !== ei) begin errors++; $display("FAIL mixed_max_idx got %0d want %0d", max_idx, ei); end
        release_out();
    endtask

    task automatic test_ones();
        int cyc;
        for (int k = 0; k < ON; k++) load_neuron(k, 8'd1, 8'd0);
        start_vec({IN{8'd1}});
        wait_done(0, cyc);
        checks++; if (cyc !== 31) begin errors++; $display("FAIL ones_latency got %0d want 31", cyc); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL ones_data got %h want 0", out_data); end
        release_out();
    endtask

    task automatic test_saturate();
        int cyc;
        for (int k = 0; k < ON; k++) load_neuron(k, 8'd127, 8'd127);
        start_vec({IN{8'hFF}});
        wait_done(0, cyc);
        checks++; if (out_data !== {ON{8'h7F}}) begin errors++; $display("FAIL sat_pos_data got %h want all 7f", out_data); end
        release_out();
        for (int k = 0; k < ON; k++) load_neuron(k, 8'h80, 8'd127);
        start_vec({IN{8'hFF}});
        wait_done(0, cyc);
        checks++; if (cyc !== 31) begin errors++; $display("FAIL sat_neg_latency got %0d want 31", cyc); end
        checks++; if (out_data !== {ON{8'h80}}) begin errors++; $display("FAIL sat_neg_data got %h want all 80", out_data); end
        release_out();
    endtask

    // Leaves the engine in DONE for the back-to-back scenario
    task automatic test_argmax_tie();
        int cyc;
        int e[ON];
        logic [3:0] ei;
        for (int k = 0; k < ON; k++) begin
            if (k == 3 || k == 7) load_neuron(k, 8'd8, 8'd5);
            else                  load_neuron(k, 8'd0, 8'd2);
        end
        e = '{2, 2, 2, 6, 2, 2, 2, 6, 2, 2};
        ei = ARGMAX ? 4'd3 : 4'd0;
        start_vec({IN{8'd1}});
        wait_done(0, cyc);
        checks++; if (out_data !== pack(e)) begin errors++; $display("FAIL tie_data got %h want %h", out_data, pack(e)); end
        checks++; if (max_idx !== ei) begin errors++; $display("FAIL tie_max_idx got %0d want %0d", max_idx, ei); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int e[ON];
        logic [ON*DW-1:0] held;
        logic [3:0] ei;
        e = '{2, 2, 2, 6, 2, 2, 2, 6, 2, 2};
        held = pack(e);
        in_data = {IN{8'hFF}};
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid cyc %0d got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, in_ready); end
            checks++; if (out_data !== held) begin errors++; $display("FAIL hold_data cyc %0d got %h want %h", i, out_data, held); end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL leave_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL leave_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL accept_in_ready got %b want 0", in_ready); end
        wait_done(0, cyc);
        e = '{2, 2, 2, 127, 2, 2, 2, 127, 2, 2};
        ei = ARGMAX ? 4'd3 : 4'd0;
        checks++; if (cyc !== 31) begin errors++; $display("FAIL b2b_latency got %0d want 31", cyc); end
        checks++; if (out_data !== pack(e)) begin errors++; $display("FAIL b2b_data got %h want %h", out_data, pack(e)); end
        checks++; if (max_idx !== ei) begin errors++; $display("FAIL b2b_max_idx got %0d want %0d", max_idx, ei); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int e[ON];
        start_vec({IN{8'd1}});
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL abort_out_data got %h want 0", out_data); end
        checks++; if (weight_addr !== 9'd443) begin errors++; $display("FAIL abort_addr got %0d want 443", weight_addr); end
        e = '{2, 2, 2, 127, 2, 2, 2, 127, 2, 2};
        start_vec({IN{8'hFF}});
        wait_done(0, cyc);
        checks++; if (cyc !== 31) begin errors++; $display("FAIL abort_new_latency got %0d want 31", cyc); end
        checks++; if (out_data !== pack(e)) begin errors++; $display("FAIL abort_new_data got %h want %h", out_data, pack(e)); end
        release_out();
    endtask

    task automatic test_sweep();
        int cyc;
        int t;
        logic [8:0] a0, a1, a2;
        rom2[510] = {8'd0,  {IN2{8'd16}}};
        rom2[511] = {8'd0,  {IN2{8'hF0}}};
        rom2[0]   = {8'd1,  {IN2{8'd32}}};
        a1 = '1; a2 = '1;
        t = 0;
        while (in_ready2 !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        in_data2  = {IN2{8'd10}};
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        cyc = 1;
        a0 = weight_addr2;
        while (out_valid2 !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 4) a1 = weight_addr2;
            if (cyc == 7) a2 = weight_addr2;
        end
        checks++; if (a0 !== 9'd510) begin errors++; $display("FAIL sweep_addr0 got %0d want 510", a0); end
        checks++; if (a1 !== 9'd511) begin errors++; $display("FAIL sweep_addr1 got %0d want 511", a1); end
        checks++; if (a2 !== 9'd0) begin errors++; $display("FAIL sweep_addr2 got %0d want 0", a2); end
        checks++; if (cyc !== 10) begin errors++; $display("FAIL sweep_latency got %0d want 10", cyc); end
        checks++; if (out_data2 !== 24'h0BFB05) begin errors++; $display("FAIL sweep_data got %h want 0bfb05", out_data2); end
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            rom[a]  = '0;
            rom2[a] = '0;
        end
        test_reset();
        test_mixed();
        test_ones();
        test_saturate();
        test_argmax_tie();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 SHALL have parameter IN_NUM, default 16, meaning input activations per neuron.
REQ-002 SHALL have parameter OUT_NUM, default 10, meaning output neurons.
REQ-003 SHALL have parameter DW, default 8, meaning activation, weight and bias width.
REQ-004 SHALL have parameter AW, default 9, meaning weight ROM address width.
REQ-005 SHALL have parameter WEIGHT_BASE, default 443, meaning ROM address of neuron 0.
REQ-006 SHALL have parameter SHIFT, default 7, meaning requantisation right-shift.
REQ-007 SHALL have ports: clk  input  1  sole clock.
REQ-008 SHALL have ports: rst  input  1  synchronous active-high reset.
REQ-009 SHALL have ports: in_valid  input  1  input vector valid.
REQ-010 SHALL have ports: in_ready  output  1  engine can accept a vector.
REQ-011 SHALL have ports: in_data  input  IN_NUM*DW  unsigned activations, lane i at [i*DW +: DW].
REQ-012 SHALL have ports: weight_addr  output  AW  ROM address.
REQ-013 SHALL have ports: weight_data  input  (IN_NUM+1)*DW  signed weights lanes 0..IN_NUM-1, signed bias in top lane; valid one cycle after address.
REQ-014 SHALL have ports: out_valid  output  1  results valid.
REQ-015 SHALL have ports: out_ready  input  1  consumer accepts results.
REQ-016 SHALL have ports: out_data  output  OUT_NUM*DW  signed results, neuron k at [k*DW +: DW].
REQ-017 SHALL have ports: max_idx  output  clog2(OUT_NUM)  argmax index (see Configuration).

Function
REQ-018 SHALL implement FSM IDLE -> FETCH -> MAC -> STORE -> (FETCH | DONE) -> IDLE, with neuron counter k.
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready latches in_data, clears k, enters FETCH.
REQ-020 weight_addr SHALL equal WEIGHT_BASE+k at all times, wrapping modulo 2^AW.
REQ-021 MAC SHALL register acc = sum(zero-extended in_data[i] * signed weight[i]) + (sign-extended bias << SHIFT), full-precision width, no overflow.
REQ-022 STORE SHALL write out_data[k] = saturate(acc >>> SHIFT) to [-2^(DW-1), 2^(DW-1)-1]; then FETCH with k+1, or DONE if k==OUT_NUM-1.
REQ-023 Latency SHALL be exactly 3*OUT_NUM+1 cycles from input handshake to out_valid rising (31 with defaults).
REQ-024 out_valid SHALL be 1 only in DONE; out_data/max_idx stable while out_valid; leave DONE on out_valid&&out_ready.
REQ-025 in_valid during a computation SHALL be ignored (not latched); a vector offered in the cycle DONE is left is accepted no earlier than the next IDLE cycle.
REQ-026 out_data entries not yet written in a pass SHALL keep prior values; out_data is only meaningful while out_valid.

Reset
REQ-027 On rst: state IDLE, k=0, in_ready=1, out_valid=0, out_data=0, max_idx=0, acc=0, weight_addr=WEIGHT_BASE.
REQ-028 rst mid-computation SHALL abort the pass immediately; no out_valid for the aborted vector.

Configuration
REQ-029 With FC_ARGMAX_EN defined, STORE SHALL track running max; max_idx = lowest index of largest out_data value, valid with out_valid.
REQ-030 Without FC_ARGMAX_EN, max_idx SHALL be constant 0 and no comparator logic is built.

Structure
REQ-031 FSM state enum and requant/saturation width constants SHALL live in shared package fc_pkg.
REQ-032 Dot-product adder tree SHALL be sub-module fc_dot_tree (IN_NUM, DW parameters, combinational, registered by parent).

Verification
REQ-033 All in_data=1, all weights=1, bias=0 -> each out_data=0 (16>>>7), out_valid at cycle 31.
REQ-034 in_data=255 all lanes, weights=127, bias=127 -> every out_data saturates to 127; weights=-128 -> -128.
REQ-035 Neuron 3 and 7 tie at max, others lower, FC_ARGMAX_EN defined -> max_idx=3; undefined -> max_idx=0.
REQ-036 out_ready held 0 for 20 cycles -> out_valid and out_data hold; in_ready=0 throughout; in_valid pulses ignored.
REQ-037 rst asserted at cycle 12 of a pass -> next cycle IDLE, in_ready=1, out_valid=0; new vector then completes in 31 cycles.
REQ-038 Parameter sweep IN_NUM=4, OUT_NUM=3, WEIGHT_BASE=510, AW=9 -> addresses 510, 511, 0 observed; latency 10.
